ysyx_23060136_idu_gpr_scoreboard: RTL and testbench

- Pending-write scoreboard for the RV64IM GPR file; sits in IDU alongside the GPR read ports.
- Tracks, per architectural register, how many issued instructions still owe a write from WBU.
- Gates instruction issue on RAW hazards (rs1/rs2 pending) and on per-register counter saturation (WAW depth).
- Releases entries on the WBU write that also updates the GPR file.

---
 rtl/ysyx_23060136_idu_gpr_scoreboard.sv | 98 +++++++++
 tb/tb_ysyx_23060136_idu_gpr_scoreboard.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060136_idu_gpr_scoreboard.sv
// Pending-write scoreboard for the GPR file: per-register count of issued writes not yet retired by WBU.
// Latency: issue_ready is combinational from registered counts; busy_vec/err_underflow update one cycle after the event.
// Backpressure: issue_ready drops on a RAW hazard or a saturated destination counter; a release only takes effect after the edge.
module ysyx_23060136_idu_gpr_scoreboard #(
    parameter int GPR_NUM = 32,
    parameter int GPR_W   = 5,
    parameter int CNT_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    input  logic [GPR_W-1:0]   issue_rd,
    input  logic               issue_wen,
    input  logic [GPR_W-1:0]   IDU_rs1,
    input  logic [GPR_W-1:0]   IDU_rs2,
    input  logic               rs1_used,
    input  logic               rs2_used,
    output logic               issue_ready,
    input  logic [GPR_W-1:0]   WBU_rd,
    input  logic               RegWr,
    input  logic               flush,
    output logic [GPR_NUM-1:0] busy_vec,
    output logic               err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt     [GPR_NUM];
    logic [CNT_W-1:0] cnt_nxt [GPR_NUM];

    logic raw1;
    logic raw2;
    logic sat;
    logic inc;
    logic dec;
    logic underflow;

    always_comb begin
        raw1        = rs1_used && (IDU_rs1 != '0) && (cnt[IDU_rs1] != '0);
        raw2        = rs2_used && (IDU_rs2 != '0) && (cnt[IDU_rs2] != '0);
        sat         = issue_wen && (issue_rd != '0) && (cnt[issue_rd] == CNT_MAX);
        issue_ready = !(raw1 || raw2 || sat);
        inc         = issue_valid && issue_ready && issue_wen && (issue_rd != '0);
        dec         = RegWr && (WBU_rd != '0) && (cnt[WBU_rd] != '0);
        underflow   = RegWr && (WBU_rd != '0) && (cnt[WBU_rd] == '0);
    end

    // Simultaneous inc and dec on the same register cancel; x0 never counts.
    always_comb begin
        for (int i = 0; i < GPR_NUM; i++) begin
            cnt_nxt[i] = cnt[i];
        end
        if (flush) begin
            for (int i = 0; i < GPR_NUM; i++) begin
                cnt_nxt[i] = '0;
            end
        end else if (inc && dec && (issue_rd == WBU_rd)) begin
            cnt_nxt[issue_rd] = cnt[issue_rd];
        end else begin
            if (inc) begin
                cnt_nxt[issue_rd] = cnt[issue_rd] + 1'b1;
            end
            if (dec) begin
                cnt_nxt[WBU_rd] = cnt[WBU_rd] - 1'b1;
            end
        end
        cnt_nxt[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < GPR_NUM; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < GPR_NUM; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_underflow <= 1'b0;
        end else if (underflow) begin
            err_underflow <= 1'b1;
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < GPR_NUM; i++) begin
            busy_vec[i] = (cnt[i] != '0);
        end
    end

endmodule

// File: tb/tb_ysyx_23060136_idu_gpr_scoreboard.sv
// Directed bench for the GPR scoreboard: hazards, saturation, same-index cancel, x0, underflow, flush, async reset.
module tb_ysyx_23060136_idu_gpr_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_wen;
    logic [4:0]  IDU_rs1;
    logic [4:0]  IDU_rs2;
    logic        rs1_used;
    logic        rs2_used;
    logic        issue_ready;
    logic [4:0]  WBU_rd;
    logic        RegWr;
    logic        flush;
    logic [31:0] busy_vec;
    logic        err_underflow;

    int checks = 0;
    int errors = 0;

    ysyx_23060136_idu_gpr_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_wen    (issue_wen),
        .IDU_rs1      (IDU_rs1),
        .IDU_rs2      (IDU_rs2),
        .rs1_used     (rs1_used),
        .rs2_used     (rs2_used),
        .issue_ready  (issue_ready),
        .WBU_rd       (WBU_rd),
        .RegWr        (RegWr),
        .flush        (flush),
        .busy_vec     (busy_vec),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = '0;
        IDU_rs1 = '0; IDU_rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
        RegWr = 1'b0; WBU_rd = '0; flush = 1'b0;
    endtask

    task automatic present(input logic [4:0] rd);
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = rd;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        #2;
        chk("reset_busy", busy_vec, 32'h0);
        chk("reset_err", err_underflow, 1'b0);
        chk("reset_ready", issue_ready, 1'b1);
        #10 rst = 1'b1;

        // RAW on x5 held until the cycle after writeback
        tick();
        present(5'd5);
        settle();
        chk("x5_issue_ready", issue_ready, 1'b1);
        tick();
        idle();
        IDU_rs1 = 5'd5; rs1_used = 1'b1;
        settle();
        chk("x5_busy", busy_vec, 32'h0000_0020);
        chk("x5_raw_blocks", issue_ready, 1'b0);
        rs1_used = 1'b0;
        settle();
        chk("x5_rs1_unused", issue_ready, 1'b1);
        rs1_used = 1'b1;
        RegWr = 1'b1; WBU_rd = 5'd5;
        settle();
        chk("x5_no_same_cycle_release", issue_ready, 1'b0);
        tick();
        RegWr = 1'b0;
        settle();
        chk("x5_released_ready", issue_ready, 1'b1);
        chk("x5_released_busy", busy_vec, 32'h0);

        // saturation of x7
        idle();
        present(5'd7);
        tick();
        tick();
        tick();
        chk("x7_busy", busy_vec, 32'h0000_0080);
        chk("x7_sat_blocks", issue_ready, 1'b0);
        RegWr = 1'b1; WBU_rd = 5'd7;
        tick();
        RegWr = 1'b0;
        settle();
        chk("x7_after_dec_ready", issue_ready, 1'b1);
        issue_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        settle();
        chk("x7_flushed", busy_vec, 32'h0);

        // same-index inc and dec cancel
        present(5'd3);
        tick();
        RegWr = 1'b1; WBU_rd = 5'd3;
        settle();
        chk("x3_ready", issue_ready, 1'b1);
        tick();
        idle();
        settle();
        chk("x3_still_busy", busy_vec, 32'h0000_0008);
        RegWr = 1'b1; WBU_rd = 5'd3;
        tick();
        idle();
        settle();
        chk("x3_released", busy_vec, 32'h0);

        // x0 ignored on every path
        present(5'd0);
        IDU_rs1 = 5'd0; rs1_used = 1'b1;
        RegWr = 1'b1; WBU_rd = 5'd0;
        settle();
        chk("x0_ready", issue_ready, 1'b1);
        tick();
        idle();
        settle();
        chk("x0_busy", busy_vec, 32'h0);
        chk("x0_err", err_underflow, 1'b0);

        // rs2 hazard
        present(5'd10);
        tick();
        idle();
        IDU_rs2 = 5'd10; rs2_used = 1'b1;
        settle();
        chk("x10_rs2_raw", issue_ready, 1'b0);
        rs2_used = 1'b0;
        settle();
        chk("x10_rs2_unused", issue_ready, 1'b1);
        flush = 1'b1;
        tick();
        idle();

        // underflow, then flush leaves the error set
        RegWr = 1'b1; WBU_rd = 5'd9;
        settle();
        chk("x9_err_not_yet", err_underflow, 1'b0);
        tick();
        idle();
        settle();
        chk("x9_err_set", err_underflow, 1'b1);
        chk("x9_busy_clear", busy_vec, 32'h0);
        present(5'd4);
        tick();
        present(5'd6);
        tick();
        chk("x4_x6_busy", busy_vec, 32'h0000_0050);
        present(5'd8);
        flush = 1'b1;
        settle();
        chk("flush_cycle_ready", issue_ready, 1'b1);
        tick();
        idle();
        settle();
        chk("flush_busy", busy_vec, 32'h0);
        chk("flush_err_sticky", err_underflow, 1'b1);

        // asynchronous reset between edges
        present(5'd12);
        tick();
        tick();
        idle();
        settle();
        chk("x12_busy", busy_vec, 32'h0000_1000);
        rst = 1'b0;
        #1;
        chk("async_rst_busy", busy_vec, 32'h0);
        chk("async_rst_err", err_underflow, 1'b0);
        #3;
        rst = 1'b1;
        tick();
        IDU_rs1 = 5'd12; rs1_used = 1'b1;
        settle();
        chk("post_rst_ready", issue_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
